// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard bus.
// Decode and writeback drive it; the regfile answers.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              alloc_en;
  logic [ADDR_W-1:0] alloc_addr;
  logic              alloc_ok;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output rd_addr1, rd_addr2,
    output we, wr_addr, wr_data,
    output alloc_en, alloc_addr,
    input  rd_data1, rd_data2,
    input  rd_busy1, rd_busy2,
    input  alloc_ok, pend_cnt
  );

  modport slave (
    input  rd_addr1, rd_addr2,
    input  we, wr_addr, wr_data,
    input  alloc_en, alloc_addr,
    output rd_data1, rd_data2,
    output rd_busy1, rd_busy2,
    output alloc_ok, pend_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending bits.
// Decode reads and allocates; writeback writes and frees.
module regfile_scoreboard #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input logic clk,
  input logic rst,
  regfile_scoreboard_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pend_nxt;
  logic [ADDR_W:0]     cnt;

  logic              wr_ok;
  logic              alloc_zero;
  logic              eff_pend;
  logic              alloc_ok;
  logic              alloc_set;
  logic              wr_clr;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rdat [2];
  logic              rbsy [2];

  assign ra[0] = bus.rd_addr1;
  assign ra[1] = bus.rd_addr2;

  assign bus.rd_data1 = rdat[0];
  assign bus.rd_data2 = rdat[1];
  assign bus.rd_busy1 = rbsy[0];
  assign bus.rd_busy2 = rbsy[1];
  assign bus.alloc_ok = alloc_ok;
  assign bus.pend_cnt = cnt;

  // Write/allocate qualification; a writeback frees its slot this cycle.
  always_comb begin
    wr_ok = bus.we &
            ~(ZERO_REG && bus.wr_addr == '0);
    alloc_zero = ZERO_REG &&
                 bus.alloc_addr == '0;
    eff_pend = pending[bus.alloc_addr] &
               ~(bus.we &&
                 bus.wr_addr == bus.alloc_addr);
    alloc_ok = bus.alloc_en & ~rst &
               (alloc_zero | ~eff_pend);
    alloc_set = alloc_ok & ~alloc_zero;
    wr_clr = wr_ok & pending[bus.wr_addr];
  end

  // Next pending vector: write clears, then a new producer sets.
  always_comb begin
    pend_nxt = pending;
    if (wr_ok)
      pend_nxt[bus.wr_addr] = 1'b0;
    if (alloc_set)
      pend_nxt[bus.alloc_addr] = 1'b1;
  end

  // Read ports: hardwired zero, then bypass, then array.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdat[p] = regs[ra[p]];
      rbsy[p] = pending[ra[p]];
      if (ZERO_REG && ra[p] == '0) begin
        rdat[p] = '0;
        rbsy[p] = 1'b0;
      end else if (BYPASS && bus.we &&
                   bus.wr_addr == ra[p]) begin
        rdat[p] = bus.wr_data;
        rbsy[p] = 1'b0;
      end
    end
  end

  // Register array and scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs    <= '{default: '0};
      pending <= '0;
      cnt     <= '0;
    end else begin
      if (wr_ok)
        regs[bus.wr_addr] <= bus.wr_data;
      pending <= pend_nxt;
      cnt <= cnt
           + (ADDR_W+1)'(alloc_set)
           - (ADDR_W+1)'(wr_clr);
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two configurations
// driven in lockstep against a behavioural model.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] rd_addr1, rd_addr2;
  logic       we;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       alloc_en;
  logic [1:0] alloc_addr;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(8), .ADDR_W(2)) ifa ();
  regfile_scoreboard_if #(.DATA_W(8), .ADDR_W(2)) ifb ();

  assign ifa.rd_addr1   = rd_addr1;
  assign ifa.rd_addr2   = rd_addr2;
  assign ifa.we         = we;
  assign ifa.wr_addr    = wr_addr;
  assign ifa.wr_data    = wr_data;
  assign ifa.alloc_en   = alloc_en;
  assign ifa.alloc_addr = alloc_addr;
  assign ifb.rd_addr1   = rd_addr1;
  assign ifb.rd_addr2   = rd_addr2;
  assign ifb.we         = we;
  assign ifb.wr_addr    = wr_addr;
  assign ifb.wr_data    = wr_data;
  assign ifb.alloc_en   = alloc_en;
  assign ifb.alloc_addr = alloc_addr;

  regfile_scoreboard #(
    .DATA_W(8), .ADDR_W(2),
    .ZERO_REG(1'b0), .BYPASS(1'b1)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  regfile_scoreboard #(
    .DATA_W(8), .ADDR_W(2),
    .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Model state per configuration.
  logic [3:0][7:0] ma_r, mb_r;
  logic [3:0]      ma_p, mb_p;

  function automatic logic [8:0] exp_rd(
    input bit zero, input bit byp,
    input logic [3:0][7:0] r, input logic [3:0] p,
    input logic [1:0] a);
    if (zero && a == 2'd0) return 9'd0;
    if (byp && we && wr_addr == a)
      return {wr_data, 1'b0};
    return {r[a], p[a]};
  endfunction

  function automatic logic exp_alloc(
    input bit zero, input logic [3:0] p);
    if (!alloc_en || rst) return 1'b0;
    if (zero && alloc_addr == 2'd0) return 1'b1;
    if (we && wr_addr == alloc_addr) return 1'b1;
    return !p[alloc_addr];
  endfunction

  function automatic logic [35:0] model_next(
    input bit zero,
    input logic [3:0][7:0] r, input logic [3:0] p);
    logic ok;
    if (rst) return 36'd0;
    ok = exp_alloc(zero, p);
    if (we && !(zero && wr_addr == 2'd0)) begin
      r[wr_addr] = wr_data;
      p[wr_addr] = 1'b0;
    end
    if (ok && !(zero && alloc_addr == 2'd0))
      p[alloc_addr] = 1'b1;
    return {r, p};
  endfunction

  always @(posedge clk) begin
    {ma_r, ma_p} <= model_next(1'b0, ma_r, ma_p);
    {mb_r, mb_p} <= model_next(1'b1, mb_r, mb_p);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [8:0] e;
      e = exp_rd(1'b0, 1'b1, ma_r, ma_p, rd_addr1);
      chk("a.rd1", {ifa.rd_data1, ifa.rd_busy1}, e);
      e = exp_rd(1'b0, 1'b1, ma_r, ma_p, rd_addr2);
      chk("a.rd2", {ifa.rd_data2, ifa.rd_busy2}, e);
      chk("a.alloc_ok", ifa.alloc_ok,
          exp_alloc(1'b0, ma_p));
      chk("a.pend_cnt", ifa.pend_cnt,
          $countones(ma_p));
      e = exp_rd(1'b1, 1'b0, mb_r, mb_p, rd_addr1);
      chk("b.rd1", {ifb.rd_data1, ifb.rd_busy1}, e);
      e = exp_rd(1'b1, 1'b0, mb_r, mb_p, rd_addr2);
      chk("b.rd2", {ifb.rd_data2, ifb.rd_busy2}, e);
      chk("b.alloc_ok", ifb.alloc_ok,
          exp_alloc(1'b1, mb_p));
      chk("b.pend_cnt", ifb.pend_cnt,
          $countones(mb_p));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0;
    we = 1'b0;
    alloc_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr1 = '0;
    rd_addr2 = '0;
    we = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    alloc_en = 1'b0;
    alloc_addr = '0;
    tick();
    rst = 1'b0;
    cmp_en = 1'b1;

    // Reset state on every address.
    for (int a = 0; a < 4; a++) begin
      rd_addr1 = 2'(a);
      rd_addr2 = 2'(a);
      @(negedge clk);
      chk("rst.data", ifa.rd_data1, 8'h00);
      chk("rst.busy", ifa.rd_busy1, 1'b0);
      chk("rst.cnt", ifa.pend_cnt, 3'd0);
      tick();
    end

    // Basic write and bypass on port 1.
    we = 1'b1; wr_addr = 2'd2; wr_data = 8'hA5;
    rd_addr1 = 2'd2;
    @(negedge clk);
    chk("wr.byp_a", ifa.rd_data1, 8'hA5);
    chk("wr.nobyp_b", ifb.rd_data1, 8'h00);
    tick();
    idle();
    @(negedge clk);
    chk("wr.read_b", ifb.rd_data1, 8'hA5);
    tick();

    // Bypass on port 2.
    we = 1'b1; wr_addr = 2'd1; wr_data = 8'h3C;
    rd_addr2 = 2'd1;
    @(negedge clk);
    chk("byp.a", ifa.rd_data2, 8'h3C);
    chk("byp.b_old", ifb.rd_data2, 8'h00);
    tick();
    idle();
    @(negedge clk);
    chk("byp.b_new", ifb.rd_data2, 8'h3C);
    tick();

    // Scoreboard allocate / reject / writeback.
    alloc_en = 1'b1; alloc_addr = 2'd3;
    rd_addr1 = 2'd3;
    @(negedge clk);
    chk("sb.ok1", ifa.alloc_ok, 1'b1);
    tick();
    @(negedge clk);
    chk("sb.busy", ifa.rd_busy1, 1'b1);
    chk("sb.cnt1", ifa.pend_cnt, 3'd1);
    chk("sb.rej", ifa.alloc_ok, 1'b0);
    tick();
    alloc_en = 1'b0;
    we = 1'b1; wr_addr = 2'd3; wr_data = 8'h7F;
    @(negedge clk);
    chk("sb.wb_byp_busy_b", ifb.rd_busy1, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk("sb.free", ifa.rd_busy1, 1'b0);
    chk("sb.cnt0", ifa.pend_cnt, 3'd0);
    chk("sb.data", ifa.rd_data1, 8'h7F);
    tick();

    // Writeback and re-allocate of the same pending reg.
    alloc_en = 1'b1; alloc_addr = 2'd3;
    tick();
    we = 1'b1; wr_addr = 2'd3; wr_data = 8'h7F;
    @(negedge clk);
    chk("same.ok", ifa.alloc_ok, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk("same.busy", ifa.rd_busy1, 1'b1);
    chk("same.cnt", ifa.pend_cnt, 3'd1);
    tick();

    // Hardwired R0 and full scoreboard, then reset.
    we = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF;
    rd_addr1 = 2'd0;
    tick();
    idle();
    @(negedge clk);
    chk("z.b_r0", ifb.rd_data1, 8'h00);
    chk("z.a_r0", ifa.rd_data1, 8'hFF);
    tick();
    alloc_en = 1'b1; alloc_addr = 2'd0;
    @(negedge clk);
    chk("z.b_ok", ifb.alloc_ok, 1'b1);
    tick();
    alloc_addr = 2'd1;
    tick();
    alloc_addr = 2'd2;
    tick();
    alloc_en = 1'b0;
    @(negedge clk);
    chk("full.a", ifa.pend_cnt, 3'd4);
    chk("full.b", ifb.pend_cnt, 3'd3);
    tick();
    rst = 1'b1;
    we = 1'b1; wr_addr = 2'd1; wr_data = 8'h55;
    alloc_en = 1'b1; alloc_addr = 2'd1;
    @(negedge clk);
    chk("rst.alloc", ifa.alloc_ok, 1'b0);
    tick();
    idle();
    rd_addr1 = 2'd1;
    rd_addr2 = 2'd2;
    @(negedge clk);
    chk("rst2.data", ifa.rd_data1, 8'h00);
    chk("rst2.busy", ifb.rd_busy2, 1'b0);
    chk("rst2.cnt", ifb.pend_cnt, 3'd0);
    tick();

    // Mixed traffic checked by the model only.
    for (int i = 0; i < 60; i++) begin
      rst = ($urandom_range(0, 24) == 0);
      rd_addr1 = 2'($urandom_range(0, 3));
      rd_addr2 = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 8'($urandom_range(0, 255));
      alloc_en = 1'($urandom_range(0, 1));
      alloc_addr = 2'($urandom_range(0, 3));
      tick();
    end
    idle();
    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
